kf8237_timing_and_control: RTL and testbench

Timing and control sequencer for the KF8237 DMA controller. It takes the one-hot channel grant from the priority encoder and runs the 8237 cycle sequence: hold request/acknowledge, address strobe, read/write strobes, wait states and end of process. It also holds the per-channel mode registers. It sits beside the bus control logic and priority encoder, and drives the pin-level bus-master strobes plus transfer-step pulses for the address/count block.

---
 rtl/kf8237_pkg.sv | 17 +
 rtl/kf8237_timing_and_control.sv | 124 ++++++++++++
 tb/tb_kf8237_timing_and_control.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/kf8237_pkg.sv
// kf8237_pkg: shared types and constants for the KF8237 DMA controller
package kf8237_pkg;

    typedef enum logic [2:0] {SI, S0, S1, S2, S3, S4, CASC} state_t;

    typedef enum logic [1:0] {DEMAND, SINGLE, BLOCK, CASCADE} mode_t;

    typedef enum logic [1:0] {VERIFY, WRITE, READ, VERIFY_ALT} xfer_t;

    localparam int CMD_DISABLE   = 2;
    localparam int CMD_EXT_WRITE = 5;

    function automatic logic [1:0] onehot_index(input logic [3:0] v);
        return v[0] ? 2'd0 : v[1] ? 2'd1 : v[2] ? 2'd2 : 2'd3;
    endfunction

endpackage

// File: rtl/kf8237_timing_and_control.sv
// kf8237_timing_and_control: DMA cycle sequencer, bus strobes and mode registers
module kf8237_timing_and_control
    import kf8237_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] internal_data_bus,
    input  logic       write_command_register,
    input  logic       write_mode_register,
    input  logic       master_clear,
    input  logic [3:0] encoded_dma,
    input  logic       ready,
    input  logic       hold_acknowledge,
    input  logic       end_of_process_n_in,
    input  logic       terminal_count,
    output logic       hold_request,
    output logic [3:0] dma_acknowledge_internal,
    output logic       lock_bus_control,
    output logic       address_enable,
    output logic       address_strobe,
    output logic       io_read_n_out,
    output logic       io_write_n_out,
    output logic       memory_read_n,
    output logic       memory_write_n,
    output logic       end_of_process_n_out,
    output logic       transfer_step,
    output logic [3:0] tc_reached
);

    state_t     state, nxt;
    logic [3:0] chan;
    logic [5:0] mode_reg [4];
    logic [5:0] sel_mode;
    mode_t      act_mode;
    xfer_t      act_xfer;
    logic       cmd_disable, cmd_ext_write;
    logic       eop_seen, eop_flag, hlda_lost;
    logic       req_held, eop_cond, late_eop, finish, enter_eop, rd_on, wr_on;
    logic       unused_mode_bits;

    // bits 3:2 (autoinit/decrement) are consumed by the address/count block
    assign sel_mode         = mode_reg[onehot_index(encoded_dma)];
    assign unused_mode_bits = ^sel_mode[3:2];

    assign req_held  = |(encoded_dma & chan);
    // the count block holds terminal_count through the final word, so it is taken on entry to S4
    assign eop_cond  = terminal_count | eop_seen | ~end_of_process_n_in;
    assign enter_eop = state == S3 && nxt == S4 && eop_cond;
    assign late_eop  = state == S4 && !eop_flag && !end_of_process_n_in;
    assign finish    = eop_flag | late_eop | hlda_lost | ~hold_acknowledge;
    assign rd_on     = nxt == S2 || nxt == S3;
    assign wr_on     = nxt == S3 || (nxt == S2 && cmd_ext_write);

    // next-state selection for the DMA cycle sequence
    always_comb begin
        nxt = state;
        case (state)
            SI:      nxt = (|encoded_dma && !cmd_disable) ? S0 : SI;
            S0:      nxt = hold_acknowledge ? (act_mode == CASCADE ? CASC : S1) : S0;
            CASC:    nxt = req_held ? CASC : SI;
            S1:      nxt = S2;
            S2:      nxt = S3;
            S3:      nxt = ready ? S4 : S3;
            S4:      nxt = (finish || act_mode == SINGLE || (act_mode == DEMAND && !req_held)) ? SI : S1;
            default: nxt = SI;
        endcase
    end

    // state, registers and outputs, all decoded from the state being entered
    always_ff @(posedge clock) begin
        if (reset || master_clear) begin
            state                    <= SI;
            chan                     <= '0;
            act_mode                 <= DEMAND;
            act_xfer                 <= VERIFY;
            cmd_disable              <= 1'b0;
            cmd_ext_write            <= 1'b0;
            eop_seen                 <= 1'b0;
            eop_flag                 <= 1'b0;
            hlda_lost                <= 1'b0;
            for (int i = 0; i < 4; i++) mode_reg[i] <= '0;
            hold_request             <= 1'b0;
            dma_acknowledge_internal <= '0;
            lock_bus_control         <= 1'b0;
            address_enable           <= 1'b0;
            address_strobe           <= 1'b0;
            io_read_n_out            <= 1'b1;
            io_write_n_out           <= 1'b1;
            memory_read_n            <= 1'b1;
            memory_write_n           <= 1'b1;
            end_of_process_n_out     <= 1'b1;
            transfer_step            <= 1'b0;
            tc_reached               <= '0;
        end else begin
            state <= nxt;
            if (state == SI && nxt == S0) begin
                chan     <= 4'b1 << onehot_index(encoded_dma);
                act_mode <= mode_t'(sel_mode[5:4]);
                act_xfer <= xfer_t'(sel_mode[1:0]);
            end
            if (write_command_register) begin
                cmd_disable   <= internal_data_bus[CMD_DISABLE];
                cmd_ext_write <= internal_data_bus[CMD_EXT_WRITE];
            end
            if (write_mode_register) mode_reg[internal_data_bus[1:0]] <= internal_data_bus[7:2];
            eop_seen  <= (nxt == SI || nxt == S1) ? 1'b0 : eop_seen | ((state == S2 || state == S3) && !end_of_process_n_in);
            eop_flag  <= enter_eop;
            hlda_lost <= nxt == SI ? 1'b0 : hlda_lost | (state inside {S1, S2, S3, S4} && !hold_acknowledge);
            hold_request             <= nxt != SI;
            dma_acknowledge_internal <= (nxt inside {S1, S2, S3, S4, CASC}) ? chan : 4'b0;
            lock_bus_control         <= nxt inside {S1, S2, S3, S4};
            address_enable           <= nxt inside {S1, S2, S3, S4};
            address_strobe           <= nxt == S1;
            io_read_n_out            <= !(rd_on && act_xfer == WRITE);
            memory_read_n            <= !(rd_on && act_xfer == READ);
            memory_write_n           <= !(wr_on && act_xfer == WRITE);
            io_write_n_out           <= !(wr_on && act_xfer == READ);
            end_of_process_n_out     <= !enter_eop;
            transfer_step            <= nxt == S4;
            tc_reached               <= (enter_eop || late_eop) ? chan : 4'b0;
        end
    end

endmodule

// File: tb/tb_kf8237_timing_and_control.sv
// tb_kf8237_timing_and_control: scoreboard bench for the DMA cycle sequencer
module tb_kf8237_timing_and_control;

    localparam int IDLE = 0, SS0 = 1, SS1 = 2, SS2 = 3, SS3 = 4, SS4 = 5, SCASC = 6;
    localparam int VER = 0, WR = 1, RD = 2;

    logic       clock = 1'b0, reset = 1'b1;
    logic [7:0] internal_data_bus;
    logic       write_command_register, write_mode_register, master_clear;
    logic [3:0] encoded_dma;
    logic       ready, hold_acknowledge, end_of_process_n_in, terminal_count;
    logic       hold_request, lock_bus_control, address_enable, address_strobe;
    logic       io_read_n_out, io_write_n_out, memory_read_n, memory_write_n;
    logic       end_of_process_n_out, transfer_step;
    logic [3:0] dma_acknowledge_internal, tc_reached;
    logic [17:0] obs;
    int          passed = 0, total = 0;
    string       tq[$];
    logic [17:0] vq[$];

    always #5 clock = ~clock;

    kf8237_timing_and_control dut (
        .clock(clock), .reset(reset), .internal_data_bus(internal_data_bus),
        .write_command_register(write_command_register), .write_mode_register(write_mode_register),
        .master_clear(master_clear), .encoded_dma(encoded_dma), .ready(ready),
        .hold_acknowledge(hold_acknowledge), .end_of_process_n_in(end_of_process_n_in),
        .terminal_count(terminal_count), .hold_request(hold_request),
        .dma_acknowledge_internal(dma_acknowledge_internal), .lock_bus_control(lock_bus_control),
        .address_enable(address_enable), .address_strobe(address_strobe),
        .io_read_n_out(io_read_n_out), .io_write_n_out(io_write_n_out),
        .memory_read_n(memory_read_n), .memory_write_n(memory_write_n),
        .end_of_process_n_out(end_of_process_n_out), .transfer_step(transfer_step),
        .tc_reached(tc_reached)
    );

    assign obs = {hold_request, dma_acknowledge_internal, lock_bus_control, address_enable,
                  address_strobe, io_read_n_out, io_write_n_out, memory_read_n, memory_write_n,
                  end_of_process_n_out, transfer_step, tc_reached};

    task automatic check(input string tag, input logic [17:0] got, input logic [17:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got %h want %h", tag, got, want);
    endtask

    // expected pin picture for each bus phase
    function automatic logic [17:0] ph(input int p, input logic [3:0] ch, input int typ, input bit ext, input bit eop);
        logic hr, lk, rd, wrs, ends;
        logic [3:0] dk;
        hr   = p != IDLE;
        dk   = (p >= SS1) ? ch : 4'b0;
        lk   = p >= SS1 && p <= SS4;
        rd   = p == SS2 || p == SS3;
        wrs  = p == SS3 || (p == SS2 && ext);
        ends = p == SS4 && eop;
        return {hr, dk, lk, lk, p == SS1, !(rd && typ == WR), !(wrs && typ == RD),
                !(rd && typ == RD), !(wrs && typ == WR), !ends, p == SS4, ends ? ch : 4'b0};
    endfunction

    // compare the pin picture of every cycle that has an expectation queued
    always @(negedge clock) if (vq.size() > 0) check(tq.pop_front(), obs, vq.pop_front());

    task automatic step(input string tag, input int p, input logic [3:0] ch = 4'b0,
                        input int typ = 0, input bit ext = 1'b0, input bit eop = 1'b0);
        @(posedge clock);
        #1;
        tq.push_back(tag);
        vq.push_back(ph(p, ch, typ, ext, eop));
    endtask

    task automatic xfer(input string tag, input logic [3:0] ch, input int typ, input bit ext,
                        input bit eop, input bit drop);
        step({tag, ".s1"}, SS1, ch, typ, ext);
        if (drop) encoded_dma = 4'b0;
        terminal_count = eop;
        step({tag, ".s2"}, SS2, ch, typ, ext);
        step({tag, ".s3"}, SS3, ch, typ, ext);
        step({tag, ".s4"}, SS4, ch, typ, ext, eop);
        terminal_count = 1'b0;
    endtask

    initial begin
        internal_data_bus = '0; write_command_register = 0; write_mode_register = 0;
        master_clear = 0; encoded_dma = '0; ready = 1; hold_acknowledge = 0;
        end_of_process_n_in = 1; terminal_count = 0;
        step("reset", IDLE);
        reset = 0;
        step("idle", IDLE);
        internal_data_bus = 8'h45; write_mode_register = 1;
        step("w.idle", IDLE);
        write_mode_register = 0; encoded_dma = 4'b0010;
        step("w.s0", SS0);
        step("w.s0wait", SS0);
        hold_acknowledge = 1;
        xfer("w", 4'b0010, WR, 0, 0, 1);
        step("w.done", IDLE);
        internal_data_bus = 8'h88; write_mode_register = 1;
        step("r.idle", IDLE);
        write_mode_register = 0; encoded_dma = 4'b0001;
        step("r.s0", SS0);
        step("r.s1", SS1, 4'b0001, RD);
        encoded_dma = 4'b0;
        step("r.s2", SS2, 4'b0001, RD);
        ready = 0;
        step("r.s3a", SS3, 4'b0001, RD);
        step("r.s3b", SS3, 4'b0001, RD);
        step("r.s3c", SS3, 4'b0001, RD);
        ready = 1; terminal_count = 1;
        step("r.s4", SS4, 4'b0001, RD, 0, 1);
        terminal_count = 0;
        step("r.done", IDLE);
        internal_data_bus = 8'h20; write_command_register = 1;
        step("b.idle", IDLE);
        write_command_register = 0; encoded_dma = 4'b0001;
        step("b.s0", SS0);
        xfer("b1", 4'b0001, RD, 1, 0, 1);
        xfer("b2", 4'b0001, RD, 1, 0, 0);
        xfer("b3", 4'b0001, RD, 1, 1, 0);
        step("b.done", IDLE);
        internal_data_bus = 8'h00; write_command_register = 1;
        step("d.idle0", IDLE);
        write_command_register = 0; internal_data_bus = 8'h07; write_mode_register = 1;
        step("d.idle1", IDLE);
        write_mode_register = 0; encoded_dma = 4'b1000;
        step("d.s0", SS0);
        xfer("d1", 4'b1000, WR, 0, 0, 0);
        xfer("d2", 4'b1000, WR, 0, 0, 1);
        step("d.done", IDLE);
        step("d.quiet", IDLE);
        internal_data_bus = 8'hC2; write_mode_register = 1;
        step("c.idle", IDLE);
        write_mode_register = 0; encoded_dma = 4'b0100;
        step("c.s0", SS0);
        step("c.casc0", SCASC, 4'b0100);
        step("c.casc1", SCASC, 4'b0100);
        encoded_dma = 4'b0;
        step("c.done", IDLE);
        internal_data_bus = 8'h45; write_mode_register = 1;
        step("m.idle", IDLE);
        write_mode_register = 0; encoded_dma = 4'b0010;
        step("m.s0", SS0);
        step("m.s1", SS1, 4'b0010, WR);
        step("m.s2", SS2, 4'b0010, WR);
        step("m.s3", SS3, 4'b0010, WR);
        master_clear = 1; encoded_dma = 4'b0;
        step("m.clr", IDLE);
        master_clear = 0; internal_data_bus = 8'h04; write_command_register = 1;
        step("x.idle", IDLE);
        write_command_register = 0; encoded_dma = 4'b0010;
        step("x.off0", IDLE);
        step("x.off1", IDLE);
        internal_data_bus = 8'h00; write_command_register = 1;
        step("x.off2", IDLE);
        write_command_register = 0;
        step("x.s0", SS0);
        xfer("x", 4'b0010, VER, 0, 0, 1);
        step("x.done", IDLE);
        @(negedge clock);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
